// File: rtl/shift_arbiter_32.sv
// shift_arbiter_32: two-requester round-robin arbiter sharing one 32-bit right barrel shifter
// Optional feature macro: SHIFT_ARBITER_SRA_EN enables arithmetic (sign-fill) shifts via reqN_arith;
// without it every result is a logical, zero-filled shift and reqN_arith is ignored.

module barrel_shr_32 (
  input  logic [31:0] i_data,
  input  logic [4:0]  i_shamt,
  output logic [31:0] o_data
);
  logic [31:0] w_stage [0:5];
  assign w_stage[0] = i_data;
  genvar s;
  generate
    for (s = 0; s < 5; s = s + 1) begin : g_stage
      assign w_stage[s+1] = i_shamt[s] ? (w_stage[s] >> (1 << s)) : w_stage[s];
    end
  endgenerate
  assign o_data = w_stage[5];
endmodule

module shift_arbiter_32 #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req0_data,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req0_select,
  input  logic [4:0]  req1_select,
  input  logic        req0_arith,
  input  logic        req1_arith,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        res_valid,
  output logic [31:0] res,
  output logic        res_id,
  input  logic        res_ready,
  output logic [15:0] done_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, OUT = 2'd2} state_t;
  state_t      r_state, w_next;
  logic        r_prio;
  logic [31:0] r_op_data;
  logic [4:0]  r_op_sel;
  logic        r_op_id;
  logic [31:0] r_res;
  logic        r_res_id;
  logic [15:0] r_done;
  logic        w_any, w_grant, w_accept, w_deliver;
  logic [31:0] w_sh_in, w_sh_out, w_result;
  assign w_any     = req0_valid | req1_valid;
  assign w_grant   = (req0_valid & req1_valid) ? r_prio : req1_valid;
  assign w_accept  = (r_state == IDLE) & w_any;
  assign w_deliver = (r_state == OUT) & res_ready;
  barrel_shr_32 u_shr (
    .i_data  (w_sh_in),
    .i_shamt (r_op_sel),
    .o_data  (w_sh_out)
  );
`ifdef SHIFT_ARBITER_SRA_EN
  logic r_op_arith;
  logic w_neg;
  assign w_neg    = r_op_arith & r_op_data[31];
  assign w_sh_in  = w_neg ? ~r_op_data : r_op_data;
  assign w_result = w_neg ? ~w_sh_out : w_sh_out;
  // sign-fill request of the accepted operand, complemented around the logical shifter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_op_arith <= 1'b0;
    else if (w_accept) r_op_arith <= w_grant ? req1_arith : req0_arith;
  end
`else
  logic w_unused_arith;
  assign w_unused_arith = req0_arith ^ req1_arith;
  assign w_sh_in        = r_op_data;
  assign w_result       = w_sh_out;
`endif
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state: IDLE waits for any valid, SHIFT lasts one cycle, OUT waits for the consumer
  always_comb begin
    w_next = (r_state == IDLE)  ? (w_any ? SHIFT : IDLE) :
             (r_state == SHIFT) ? OUT : (res_ready ? IDLE : OUT);
  end
  // outputs: readys only in IDLE for the granted requester, never during reset
  always_comb begin
    req0_ready = ~reset & w_accept & ~w_grant;
    req1_ready = ~reset & w_accept & w_grant;
    res_valid  = (r_state == OUT);
  end
  // capture the granted operand and hand priority to the requester that was not served
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_data <= '0;
      r_op_sel  <= '0;
      r_op_id   <= 1'b0;
      r_prio    <= PRIO_INIT;
    end else if (w_accept) begin
      r_op_data <= w_grant ? req1_data : req0_data;
      r_op_sel  <= w_grant ? req1_select : req0_select;
      r_op_id   <= w_grant;
      r_prio    <= ~w_grant;
    end
  end
  // register the shifter result at the end of SHIFT; it then holds through OUT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res    <= '0;
      r_res_id <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_res    <= w_result;
      r_res_id <= r_op_id;
    end
  end
  // count delivered results, wrapping naturally at 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_done <= '0;
    else if (w_deliver) r_done <= r_done + 16'd1;
  end
  assign res        = r_res;
  assign res_id     = r_res_id;
  assign done_count = r_done;
endmodule

// File: doc/shift_arbiter_32.md
SHIFT_ARBITER_32 -- requirements
Module: shift_arbiter_32

Interface
REQ-001 SHALL have parameter: PRIO_INIT, 0, requester holding round-robin priority after reset (0 or 1).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 SHALL have ports: req0_data / req1_data  input  32  operand to shift.
REQ-006 SHALL have ports: req0_select / req1_select  input  5  right-shift amount 0..31.
REQ-007 SHALL have ports: req0_arith / req1_arith  input  1  1 = arithmetic shift request.
REQ-008 SHALL have ports: req0_ready / req1_ready  output  1  operation accepted this cycle when valid&ready.
REQ-009 SHALL have port: res_valid  output  1  result available.
REQ-010 SHALL have port: res  output  32  shifted result.
REQ-011 SHALL have port: res_id  output  1  requester that owns res.
REQ-012 SHALL have port: res_ready  input  1  consumer accepts result when res_valid&res_ready.
REQ-013 SHALL have port: done_count  output  16  count of results delivered.

Function
REQ-014 SHALL contain exactly one instance of the team's 32-bit logical right barrel shifter, shared by both requesters.
REQ-015 SHALL use a three-state FSM: IDLE, SHIFT, OUT.
REQ-016 IDLE: grant = sole valid requester; both valid -> requester holding priority; none valid -> stay IDLE.
REQ-017 reqN_ready SHALL be high only in IDLE for the granted requester (combinational from valids and priority); the other ready low.
REQ-018 On accept SHALL latch data, select, arith, id into operand registers, toggle priority to the other requester, go SHIFT.
REQ-019 SHIFT: shifter driven from operand registers; res and res_id registered at end of cycle; go OUT.
REQ-020 OUT: res_valid=1, res/res_id stable until res_ready; on handshake increment done_count, go IDLE.
REQ-021 Latency SHALL be: accept at cycle N -> res_valid high at cycle N+2; minimum 3 cycles per operation.
REQ-022 Priority SHALL toggle only on accept; a lone requester does not lose priority it did not hold, and one-sided traffic is never stalled.
REQ-023 select=0 SHALL return data unchanged; select=31 SHALL return data[31] in bit 0 (logical) with zero fill above.
REQ-024 done_count SHALL wrap 16'hFFFF -> 0.
REQ-025 reqN_valid changes while not ready SHALL have no effect; no request is ever accepted outside IDLE.

Reset
REQ-026 reset SHALL force: state IDLE, res_valid 0, res 0, res_id 0, done_count 0, operand registers 0, priority PRIO_INIT, asynchronously.
REQ-027 reset asserted in SHIFT or OUT SHALL discard the in-flight operation without counting it.
REQ-028 reqN_ready SHALL be 0 while reset is asserted.

Configuration
REQ-029 Macro SHIFT_ARBITER_SRA_EN SHALL enable arithmetic shift.
REQ-030 Defined: arith=1 and data[31]=1 -> result = ~shift(~data, select) (sign fill); arith=0 or data[31]=0 -> logical result.
REQ-031 Not defined: arith inputs ignored; every result logical, zero fill.

Verification
REQ-032 Reset then req0 {data 32'h8000_0000, select 4, arith 0} -> req0_ready same cycle, res_valid at N+2, res 32'h0800_0000, res_id 0, done_count 1.
REQ-033 Both valid same cycle with PRIO_INIT=0, req0 {32'hFFFF_0000, 16}, req1 {32'h0000_00F0, 4} -> req0 served first (res 32'h0000_FFFF), then req1 (res 32'h0000_000F, res_id 1); next contention grants req0 again.
REQ-034 res_ready held low 5 cycles in OUT -> res and res_valid stable, both readys low, done_count unchanged until handshake.
REQ-035 SHIFT_ARBITER_SRA_EN defined, {32'hF000_0000, select 8, arith 1} -> res 32'hFFF0_0000; undefined -> 32'h00F0_0000.
REQ-036 reset pulsed during SHIFT -> res_valid 0, done_count unchanged, next accepted request completes normally.
REQ-037 select 0 on 32'hDEAD_BEEF -> res 32'hDEAD_BEEF; preload 16'hFFFF deliveries then one more -> done_count 0.
